// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and stall controller for the 5-stage core. It does four jobs:
//   * Selects the Execute-stage forwarding source for each operand. The
//     Memory stage has priority over Writeback, and x0 is never forwarded.
//   * Detects a load-use hazard. It stalls Fetch and Decode and inserts a
//     bubble into Execute.
//   * Flushes Decode and Execute on a branch or jump taken in Execute.
//   * Sequences multi-cycle stalls while the SPI-backed data memory
//     completes a request. The wait is bounded: a timeout falls into a
//     sticky error state that only reset leaves.
//
// Optional build macro:
//   HAZARD_STALL_CNT_EN
//     Defined:   StallCount is a saturating 32-bit count of the clock edges
//                on which StallF is high.
//     Undefined: StallCount is tied to zero.
//
// Parameters:
//   TIMEOUT_CYC  maximum number of cycles spent in MEM_WAIT before MEM_ERR
//   CNT_W        wait counter width; 2**CNT_W must exceed TIMEOUT_CYC
//
// Ports:
//   CLK, RST_N              clock (rising edge), asynchronous active-low reset
//   Rs1D, Rs2D              Decode source registers
//   Rs1E, Rs2E, RdE         Execute register fields
//   ResultSrcE              Execute result source (2'b01 = load)
//   PCSrcE                  taken branch or jump resolved in Execute
//   RdM, RdW                Memory and Writeback destination registers
//   RegWriteM, RegWriteW    Memory and Writeback write enables
//   MemReqM                 load or store present in the Memory stage
//   MemReadyM               SPI memory completion (a pulse or held high)
//   ForwardAE, ForwardBE    2'b00 = register file, 2'b10 = M, 2'b01 = W
//   StallF/D/E/M            hold the PC or the named pipeline register
//   FlushD/E/W              clear the named pipeline register
//   MemErr                  sticky memory timeout flag
//   StallCount              stall-cycle count (see the build macro above)
// ----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemErr,
  output logic [31:0] StallCount
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic idle_rules;
  logic lw_stall;

  // --------------------------------------------------------------------------
  // Forwarding. Both operands use identical logic, so one generate loop
  // builds both selectors.
  // --------------------------------------------------------------------------
  logic [4:0] rs_e [2];
  logic [1:0] fwd  [2];

  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic hit_m, hit_w;
    assign hit_m   = RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi]);
    assign hit_w   = RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi]);
    assign fwd[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
  end

  // Load-use hazard: the instruction in Execute is a load, and its
  // destination is a source of the instruction in Decode.
  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  // --------------------------------------------------------------------------
  // FSM state register and wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    idle_rules = 1'b0;

    case (state_reg)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          // Freeze the whole pipeline from the first cycle of the request.
          // Load-use and branch actions wait until the memory completes.
          state_next = MEM_WAIT;
          cnt_next   = '0;
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          stall_e    = 1'b1;
          stall_m    = 1'b1;
          flush_w    = 1'b1;
        end else begin
          idle_rules = 1'b1;
        end
      end

      MEM_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (MemReadyM) begin
          // Release in the completion cycle. Execute has been frozen, so
          // its branch and load-use conditions are evaluated again now.
          state_next = IDLE;
          idle_rules = 1'b1;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_next = MEM_ERR;
          end
        end
      end

      MEM_ERR: begin
        // Terminal until reset. MemReadyM is deliberately ignored here.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (idle_rules) begin
      // A taken branch discards the stalled instruction anyway, so the
      // branch wins over a load-use stall.
      if (PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. While reset is held low, the pipeline is kept flushed and
  // never stalled, independent of the registered state.
  // --------------------------------------------------------------------------
  assign ForwardAE = RST_N ? fwd[0] : 2'b00;
  assign ForwardBE = RST_N ? fwd[1] : 2'b00;
  assign StallF    = RST_N & stall_f;
  assign StallD    = RST_N & stall_d;
  assign StallE    = RST_N & stall_e;
  assign StallM    = RST_N & stall_m;
  assign FlushD    = ~RST_N | flush_d;
  assign FlushE    = ~RST_N | flush_e;
  assign FlushW    = RST_N & flush_w;
  assign MemErr    = (state_reg == MEM_ERR);

  // --------------------------------------------------------------------------
  // Optional stall-cycle counter
  // --------------------------------------------------------------------------
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_reg <= '0;
    end else if (stall_f && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign StallCount = stall_cnt_reg;
`else
  assign StallCount = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl. It covers reset, forwarding, load-use,
// branch priority, the memory wait, the timeout error state, and reset during
// a wait. The DUT is built with TIMEOUT_CYC = 8.
//
// The control outputs are grouped as
//   ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW, MemErr;
  logic [31:0] StallCount;

  int checks = 0;
  int errors = 0;

`ifdef HAZARD_STALL_CNT_EN
  localparam int SC_EN = 1;
`else
  localparam int SC_EN = 0;
`endif

  // Named control patterns
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_RST  = 8'b0000_1100;  // FlushD, FlushE
  localparam logic [7:0] C_LU   = 8'b1100_0100;  // StallF, StallD, FlushE
  localparam logic [7:0] C_BR   = 8'b0000_1100;  // FlushD, FlushE
  localparam logic [7:0] C_WAIT = 8'b1111_0010;  // four stalls, FlushW
  localparam logic [7:0] C_ERR  = 8'b1111_0011;  // C_WAIT plus MemErr

  always #5 CLK = ~CLK;

  hazard_ctrl #(
    .TIMEOUT_CYC (8),
    .CNT_W       (4)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .MemErr     (MemErr),
    .StallCount (StallCount)
  );

  logic [7:0] ctl;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s observed=%0h", tag, obs);
    end
  endtask

  // Advance one clock edge. Inputs change and outputs are sampled 1 ns
  // after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  initial begin
    clear_inputs();
    RST_N = 1'b0;
    #2;
    check("rst_ctl", 32'(ctl), 32'(C_RST));
    check("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'h0);
    check("rst_sc", StallCount, 32'h0);

    tick();
    RST_N = 1'b1;
    #1;
    check("idle_ctl", 32'(ctl), 32'(C_NONE));

    // Forwarding
    RegWriteM = 1; RdM = 5; Rs1E = 5; Rs2E = 5; RegWriteW = 1; RdW = 5;
    #1;
    check("fwd_a_m_prio", 32'(ForwardAE), 32'h2);
    check("fwd_b_m_prio", 32'(ForwardBE), 32'h2);
    Rs2E = 6;
    #1;
    check("fwd_b_nomatch", 32'(ForwardBE), 32'h0);
    Rs2E = 5; RegWriteM = 0;
    #1;
    check("fwd_a_w", 32'(ForwardAE), 32'h1);
    RegWriteM = 1; RdM = 3;
    #1;
    check("fwd_a_w_rdm_diff", 32'(ForwardAE), 32'h1);
    RdM = 0; RdW = 0;
    #1;
    check("fwd_a_x0", 32'(ForwardAE), 32'h0);
    check("fwd_b_x0", 32'(ForwardBE), 32'h0);
    clear_inputs();

    // Load-use, held over one edge so the optional counter moves by 1
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    check("lu_rs2", 32'(ctl), 32'(C_LU));
    tick();
    RdE = 0; Rs2D = 0;
    #1;
    check("lu_rd0", 32'(ctl), 32'(C_NONE));
    ResultSrcE = 2'b00; RdE = 7; Rs1D = 7;
    #1;
    check("lu_not_load", 32'(ctl), 32'(C_NONE));
    ResultSrcE = 2'b01;
    #1;
    check("lu_rs1", 32'(ctl), 32'(C_LU));
    PCSrcE = 1;
    #1;
    check("branch_over_lu", 32'(ctl), 32'(C_BR));
    clear_inputs();
    #1;
    check("sc_after_lu", StallCount, 32'(SC_EN * 1));

    // Memory request with ready already high: no stall
    MemReqM = 1; MemReadyM = 1;
    #1;
    check("mem_ready_now", 32'(ctl), 32'(C_NONE));

    // Memory wait: the request cycle plus 3 wait cycles are stalled, and
    // ready arrives in the fourth wait cycle. A pending branch is held back
    // during the wait and acted on in the completion cycle.
    MemReadyM = 0; PCSrcE = 1;
    #1;
    check("mem_req", 32'(ctl), 32'(C_WAIT));
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mem_wait%0d", i), 32'(ctl), 32'(C_WAIT));
      tick();
    end
    MemReadyM = 1;
    #1;
    check("mem_ready_branch", 32'(ctl), 32'(C_BR));
    tick();
    MemReqM = 0; MemReadyM = 0; PCSrcE = 0;
    #1;
    check("mem_idle", 32'(ctl), 32'(C_NONE));
    check("sc_after_mem", StallCount, 32'(SC_EN * 5));

    // Timeout: 8 cycles in MEM_WAIT, then MEM_ERR
    MemReqM = 1;
    #1;
    check("to_req", 32'(ctl), 32'(C_WAIT));
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to_wait%0d", i), 32'(ctl), 32'(C_WAIT));
      tick();
    end
    check("to_err", 32'(ctl), 32'(C_ERR));
    MemReqM = 0; MemReadyM = 1;
    tick();
    check("err_ignores_ready", 32'(ctl), 32'(C_ERR));
    MemReadyM = 0;
    tick();
    check("err_sticky", 32'(ctl), 32'(C_ERR));
    check("sc_in_err", StallCount, 32'(SC_EN * 16));

    // Reset leaves MEM_ERR
    RST_N = 0;
    #1;
    check("rst_err_ctl", 32'(ctl), 32'(C_RST));
    check("rst_err_sc", StallCount, 32'h0);
    RST_N = 1;
    #1;
    check("post_err_idle", 32'(ctl), 32'(C_NONE));

    // Reset during MEM_WAIT
    MemReqM = 1;
    tick();
    tick();
    MemReqM = 0;
    #1;
    check("wait_hold", 32'(ctl), 32'(C_WAIT));
    RST_N = 0;
    #1;
    check("rst_wait_ctl", 32'(ctl), 32'(C_RST));
    tick();
    RST_N = 1;
    #1;
    check("post_wait_rst", 32'(ctl), 32'(C_NONE));
    tick();
    check("post_wait_idle", 32'(ctl), 32'(C_NONE));

    // After reset the wait counter starts from zero, so a new request
    // again times out after exactly 8 wait cycles.
    MemReqM = 1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("rewait_last", 32'(ctl), 32'(C_WAIT));
    tick();
    check("rewait_err", 32'(ctl), 32'(C_ERR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
